clk_ratio_detect: RTL and testbench



---
 rtl/clk_ratio_detect_pkg.sv | 20 ++
 rtl/clk_ratio_detect_edge_sampler.sv | 46 ++++
 rtl/clk_ratio_detect.sv | 165 ++++++++++++++++
 tb/tb_clk_ratio_detect.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ratio_detect_pkg.sv
// Shared definitions for clk_ratio_detect: FSM encoding, default sizing and
// the saturating increment used by every counter in the block.
package clk_ratio_detect_pkg;

  localparam int DEF_RATIO_W  = 8;
  localparam int DEF_LOCK_CNT = 3;
  localparam int DEF_TIMEOUT  = 1023;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEAS_HIGH = 2'd2,
    ST_MEAS_LOW  = 2'd3
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/clk_ratio_detect_edge_sampler.sv
// Samples the divided clock as data and produces rise/fall pulses.
// Define CLK_SYNC_EN to add a two-flop synchronizer for asynchronous inputs.
module clk_ratio_detect_edge_sampler (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);

  logic din;
  logic s_q;
  logic s_prev_q;

`ifdef CLK_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], i_d};
    end
  end

  assign din = sync_q[1];
`else
  assign din = i_d;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      s_q      <= din;
      s_prev_q <= s_q;
    end
  end

  assign o_s    = s_q;
  assign o_rise = s_q & ~s_prev_q;
  assign o_fall = ~s_q & s_prev_q;

endmodule

// File: rtl/clk_ratio_detect.sv
// Recovers divide ratio, high and low time of a divided clock in reference
// cycles; flags lock, duty error and stall. Optional macro: CLK_SYNC_EN.
module clk_ratio_detect
  import clk_ratio_detect_pkg::*;
#(
  parameter int RATIO_W  = DEF_RATIO_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic               i_ref_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_div_clk,
  output logic [RATIO_W-1:0] o_ratio,
  output logic [RATIO_W-1:0] o_high_cnt,
  output logic [RATIO_W-1:0] o_low_cnt,
  output logic               o_valid,
  output logic               o_lock,
  output logic               o_duty_err,
  output logic               o_timeout,
  output logic [1:0]         o_dbg_state
);

  localparam int unsigned CNT_MAX = (1 << RATIO_W) - 1;
  localparam int          TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  LOCK_TH = 4'(LOCK_CNT);

  logic s, rise, fall;

  clk_ratio_detect_edge_sampler u_sampler (
    .i_clk  (i_ref_clk),
    .i_rst  (i_rst),
    .i_d    (i_div_clk),
    .o_s    (s),
    .o_rise (rise),
    .o_fall (fall)
  );

  state_e             state_q, state_d;
  logic [RATIO_W-1:0] high_q, high_d, low_q, low_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [3:0]         mcnt_q, mcnt_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d, hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic               valid_q, valid_d, lock_q, lock_d;
  logic               duty_q, duty_d, tout_q, tout_d;

  logic [RATIO_W-1:0] new_ratio;
  logic [RATIO_W:0]   hx, lx;
  logic               hit;

  assign new_ratio = high_q + low_q;
  assign hx        = {1'b0, high_q};
  assign lx        = {1'b0, low_q};

  always_comb begin
    state_d = state_q;
    high_d  = high_q;
    low_d   = low_q;
    mcnt_d  = mcnt_q;
    ratio_d = ratio_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    valid_d = 1'b0;
    lock_d  = lock_q;
    duty_d  = duty_q;
    tout_d  = tout_q;
    // Stall counter saturates at TIMEOUT so the stall keeps re-arming until an edge.
    to_d    = (rise | fall) ? '0 : TO_W'(sat_inc(32'(to_q), 32'(TIMEOUT)));
    hit     = (to_d == TO_W'(TIMEOUT));

    if (!i_en) begin
      state_d = ST_IDLE;
      lock_d  = 1'b0;
      tout_d  = 1'b0;
      mcnt_d  = '0;
      to_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_RISE;
          to_d    = '0;
        end
        ST_WAIT_RISE: begin
          if (rise) begin
            high_d  = RATIO_W'(1);
            state_d = ST_MEAS_HIGH;
          end
        end
        ST_MEAS_HIGH: begin
          if (fall) begin
            low_d   = RATIO_W'(1);
            state_d = ST_MEAS_LOW;
          end else if (s) begin
            high_d = RATIO_W'(sat_inc(32'(high_q), CNT_MAX));
          end
        end
        ST_MEAS_LOW: begin
          if (rise) begin
            ratio_d = new_ratio;
            hcnt_d  = high_q;
            lcnt_d  = low_q;
            valid_d = 1'b1;
            duty_d  = (hx > lx + (RATIO_W+1)'(1)) || (lx > hx + (RATIO_W+1)'(1));
            tout_d  = 1'b0;
            mcnt_d  = (new_ratio == ratio_q) ? 4'(sat_inc(32'(mcnt_q), 32'd15)) : 4'd1;
            lock_d  = (mcnt_d >= LOCK_TH);
            high_d  = RATIO_W'(1);
            state_d = ST_MEAS_HIGH;
          end else if (!s) begin
            low_d = RATIO_W'(sat_inc(32'(low_q), CNT_MAX));
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // A stall also restarts lock acquisition from scratch.
      if (state_q != ST_IDLE && hit) begin
        tout_d  = 1'b1;
        lock_d  = 1'b0;
        mcnt_d  = '0;
        state_d = ST_WAIT_RISE;
      end
    end
  end

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      high_q  <= '0;
      low_q   <= '0;
      to_q    <= '0;
      mcnt_q  <= '0;
      ratio_q <= '0;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
      duty_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      high_q  <= high_d;
      low_q   <= low_d;
      to_q    <= to_d;
      mcnt_q  <= mcnt_d;
      ratio_q <= ratio_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
      duty_q  <= duty_d;
      tout_q  <= tout_d;
    end
  end

  assign o_ratio     = ratio_q;
  assign o_high_cnt  = hcnt_q;
  assign o_low_cnt   = lcnt_q;
  assign o_valid     = valid_q;
  assign o_lock      = lock_q;
  assign o_duty_err  = duty_q;
  assign o_timeout   = tout_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_clk_ratio_detect.sv
// Bench for clk_ratio_detect: drives whole divided-clock periods and checks
// every publication against expectations derived from the driven periods.
module tb_clk_ratio_detect;
  import clk_ratio_detect_pkg::*;

  localparam int LOCK_N = 3;
  localparam int REC_W  = 26;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       div;
  logic [7:0] o_ratio, o_high_cnt, o_low_cnt;
  logic       o_valid, o_lock, o_duty_err, o_timeout;
  logic [1:0] o_dbg_state;

  clk_ratio_detect dut (
    .i_ref_clk   (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_div_clk   (div),
    .o_ratio     (o_ratio),
    .o_high_cnt  (o_high_cnt),
    .o_low_cnt   (o_low_cnt),
    .o_valid     (o_valid),
    .o_lock      (o_lock),
    .o_duty_err  (o_duty_err),
    .o_timeout   (o_timeout),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0] ratio;
    logic [7:0] high;
    logic [7:0] low;
    logic       duty;
    logic       lock;
  } rec_t;

  typedef struct {
    int h;
    int l;
    int n;
    int exp_ratio;
    int exp_high;
    int exp_low;
    bit exp_duty;
  } vec_t;

  logic [REC_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Model: last published ratio, run length of equal ratios, period awaiting its closing rise.
  int   m_ratio = 0;
  int   m_mcnt  = 0;
  bit   pend_v  = 1'b0;
  rec_t pend;
  rec_t mon_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void publish_pending();
    rec_t r;
    if (pend_v) begin
      if (int'(pend.ratio) == m_ratio) m_mcnt = (m_mcnt < 15) ? m_mcnt + 1 : 15;
      else m_mcnt = 1;
      m_ratio = int'(pend.ratio);
      r       = pend;
      r.lock  = (m_mcnt >= LOCK_N);
      exp_q.push_back(r);
      pend_v  = 1'b0;
    end
  endfunction

  function automatic void model_clear_lock();
    pend_v = 1'b0;
    m_mcnt = 0;
  endfunction

  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ratio", int'(o_ratio), int'(mon_e.ratio));
        chk("high_cnt", int'(o_high_cnt), int'(mon_e.high));
        chk("low_cnt", int'(o_low_cnt), int'(mon_e.low));
        chk("duty_err", int'(o_duty_err), int'(mon_e.duty));
        chk("lock", int'(o_lock), int'(mon_e.lock));
        chk("timeout_at_valid", int'(o_timeout), 0);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_period(input int h, input int l, input int r, input int hh,
                              input int ll, input bit d);
    publish_pending();
    pend.ratio = 8'(r);
    pend.high  = 8'(hh);
    pend.low   = 8'(ll);
    pend.duty  = d;
    pend.lock  = 1'b0;
    pend_v     = 1'b1;
    div = 1'b1;
    repeat (h) @(posedge clk);
    #1 div = 1'b0;
    repeat (l) @(posedge clk);
    #1;
  endtask

  // Abstract reference: counts are the driven lengths clipped at 255, ratio wraps mod 256.
  task automatic drive_model_period(input int h, input int l);
    int hh, ll, r;
    bit d;
    hh = (h > 255) ? 255 : h;
    ll = (l > 255) ? 255 : l;
    r  = (hh + ll) % 256;
    d  = (hh - ll > 1) || (ll - hh > 1);
    drive_period(h, l, r, hh, ll, d);
  endtask

  task automatic drive_partial(input int h, input int l);
    publish_pending();
    div = 1'b1;
    repeat (h) @(posedge clk);
    #1 div = 1'b0;
    repeat (l) @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- test ----------------
  vec_t tbl[9];

  initial begin
    tbl[0] = '{2, 2, 5, 4, 2, 2, 1'b0};
    tbl[1] = '{1, 1, 4, 2, 1, 1, 1'b0};
    tbl[2] = '{3, 4, 4, 7, 3, 4, 1'b0};
    tbl[3] = '{6, 2, 3, 8, 6, 2, 1'b1};
    tbl[4] = '{3, 3, 4, 6, 3, 3, 1'b0};
    tbl[5] = '{3, 2, 4, 5, 3, 2, 1'b0};
    tbl[6] = '{300, 2, 2, 1, 255, 2, 1'b1};
    tbl[7] = '{3, 260, 2, 2, 3, 255, 1'b1};
    tbl[8] = '{4, 3, 3, 7, 4, 3, 1'b0};

    rst = 1'b1;
    en  = 1'b0;
    div = 1'b0;
    pend = '0;
    wait_cycles(3);
    chk("rst_ratio", int'(o_ratio), 0);
    chk("rst_high", int'(o_high_cnt), 0);
    chk("rst_low", int'(o_low_cnt), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_lock", int'(o_lock), 0);
    chk("rst_duty", int'(o_duty_err), 0);
    chk("rst_timeout", int'(o_timeout), 0);
    chk("rst_state", int'(o_dbg_state), int'(ST_IDLE));

    rst = 1'b0;
    wait_cycles(1);
    en = 1'b1;
    wait_cycles(6);

    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        drive_period(tbl[i].h, tbl[i].l, tbl[i].exp_ratio, tbl[i].exp_high,
                     tbl[i].exp_low, tbl[i].exp_duty);
      end
    end

    // Stall: lock survives a long low, then drops once the stall limit passes.
    for (int k = 0; k < 4; k++) drive_model_period(4, 4);
    wait_cycles(900);
    chk("pre_timeout_flag", int'(o_timeout), 0);
    chk("pre_timeout_lock", int'(o_lock), 1);
    wait_cycles(200);
    model_clear_lock();
    chk("timeout_flag", int'(o_timeout), 1);
    chk("timeout_lock", int'(o_lock), 0);
    chk("timeout_ratio_hold", int'(o_ratio), 8);
    chk("timeout_state", int'(o_dbg_state), int'(ST_WAIT_RISE));
    drive_model_period(5, 5);
    chk("timeout_sticky_first_rise", int'(o_timeout), 1);
    for (int k = 0; k < 3; k++) drive_model_period(5, 5);
    chk("timeout_cleared", int'(o_timeout), 0);
    chk("relock_after_timeout", int'(o_lock), 1);

    // Enable dropped mid low phase: partial period discarded, published values hold.
    drive_partial(4, 3);
    en = 1'b0;
    wait_cycles(3);
    model_clear_lock();
    chk("en_drop_state", int'(o_dbg_state), int'(ST_IDLE));
    chk("en_drop_lock", int'(o_lock), 0);
    chk("en_drop_ratio_hold", int'(o_ratio), 10);
    chk("en_drop_high_hold", int'(o_high_cnt), 5);
    chk("en_drop_low_hold", int'(o_low_cnt), 5);
    div = 1'b1;
    wait_cycles(5);
    div = 1'b0;
    wait_cycles(10);
    chk("en_drop_no_drain", exp_q.size(), 0);
    en = 1'b1;
    wait_cycles(6);

    // Randomized runs of repeated periods against the abstract model.
    for (int i = 0; i < 30; i++) begin
      int h, l, reps;
      h    = $urandom_range(1, 12);
      l    = $urandom_range(1, 12);
      reps = $urandom_range(1, 5);
      for (int k = 0; k < reps; k++) drive_model_period(h, l);
    end

    // Asynchronous reset mid low phase.
    drive_partial(3, 8);
    rst = 1'b1;
    #1;
    chk("midrst_ratio", int'(o_ratio), 0);
    chk("midrst_high", int'(o_high_cnt), 0);
    chk("midrst_low", int'(o_low_cnt), 0);
    chk("midrst_valid", int'(o_valid), 0);
    chk("midrst_lock", int'(o_lock), 0);
    chk("midrst_duty", int'(o_duty_err), 0);
    chk("midrst_timeout", int'(o_timeout), 0);
    chk("midrst_state", int'(o_dbg_state), int'(ST_IDLE));
    exp_q.delete();
    model_clear_lock();
    m_ratio = 0;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(6);
    for (int k = 0; k < 4; k++) drive_model_period(2, 3);
    wait_cycles(20);
    chk("final_drain", exp_q.size(), 0);
    chk("final_lock", int'(o_lock), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
